// File: rtl/feature_map_pingpong_buffer.sv
// feature_map_pingpong_buffer: two-bank ping-pong feature map store between a producer and a consumer layer
module feature_map_pingpong_buffer #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_done,
   output logic                  wr_ready,
   output logic [ADDR_WIDTH:0]   wr_count,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_ready,
   input  logic                  rd_release,
   output logic                  err
);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   // storage is indexed by {bank, addr}; entries at addr >= DEPTH are never accessed
   logic [DATA_WIDTH-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];
   logic                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
   logic [1:0]            full_q, full_d;
   logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d, err_q, err_d;
   logic                  wr_in, rd_in, wr_ok, rd_ok, wr_seal, rd_rel;
   assign wr_ready = !full_q[wr_sel_q];
   assign rd_ready = full_q[rd_sel_q];
   assign wr_count = wr_count_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign err      = err_q;
   always_comb begin
      wr_in      = {1'b0, wr_addr} < DEPTH_W;
      rd_in      = {1'b0, rd_addr} < DEPTH_W;
      wr_ok      = wr_valid && wr_ready && wr_in;
      rd_ok      = rd_en && rd_ready && rd_in;
      wr_seal    = wr_done && wr_ready;
      rd_rel     = rd_release && rd_ready;
      full_d     = full_q;
      if (wr_seal) full_d[wr_sel_q] = 1'b1;
      if (rd_rel) full_d[rd_sel_q] = 1'b0;
      wr_sel_d   = wr_seal ? !wr_sel_q : wr_sel_q;
      rd_sel_d   = rd_rel ? !rd_sel_q : rd_sel_q;
      // a write coinciding with the seal belongs to the old bank, so the new count starts at zero
      wr_count_d = wr_seal ? '0 : (wr_ok && wr_count_q != DEPTH_W) ? wr_count_q + 1'b1 : wr_count_q;
      rd_valid_d = rd_ok;
      rd_data_d  = rd_ok ? mem[{rd_sel_q, rd_addr}] : rd_data_q;
      err_d      = err_q || (wr_valid && !(wr_ready && wr_in)) || (wr_done && !wr_ready)
                || (rd_en && !(rd_ready && rd_in)) || (rd_release && !rd_ready);
   end
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[{wr_sel_q, wr_addr}] <= wr_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         full_q     <= 2'b00;
         wr_count_q <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         full_q     <= full_d;
         wr_count_q <= wr_count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_feature_map_pingpong_buffer.sv
// tb_feature_map_pingpong_buffer: directed scoreboard bench for the ping-pong feature map buffer
module tb_feature_map_pingpong_buffer;
   localparam int DEPTH = 16;
   localparam int DW    = 16;
   localparam int AW    = 5;
   logic          clk = 1'b0;
   logic          reset, wr_valid, wr_done, rd_en, rd_release;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic [AW:0]   wr_count;
   logic          wr_ready, rd_valid, rd_ready, err;
   logic [DW-1:0] sb [$];
   logic          rd_exp_v;
   int            total = 0;
   int            bad = 0;
   feature_map_pingpong_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .wr_ready(wr_ready), .wr_count(wr_count), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_release(rd_release), .err(err)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd_exp_v});
      if (rd_valid) begin
         if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
         else chk("rd_data", {16'b0, rd_data}, {16'b0, sb.pop_front()});
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      rd_exp_v = 1'b0;
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask
   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask
   task automatic seal();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
   endtask
   task automatic release_bank();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
   endtask
   task automatic rd(input int a, input logic [DW-1:0] exp, input logic legal);
      rd_en = 1'b1;
      rd_addr = AW'(a);
      if (legal) sb.push_back(exp);
      rd_exp_v = legal;
      tick();
      rd_en = 1'b0;
      rd_exp_v = 1'b0;
   endtask
   initial begin
      {wr_valid, wr_done, rd_en, rd_release} = '0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
      do_reset();
      chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
      chk("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
      chk("rst_wr_count", {26'b0, wr_count}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
      // basic frame: signed ramp -8..7
      for (int i = 0; i < DEPTH; i++) wr(i, DW'(i - 8));
      chk("fill_count", {26'b0, wr_count}, 32'd16);
      seal();
      chk("seal_rd_ready", {31'b0, rd_ready}, 32'd1);
      chk("seal_wr_ready", {31'b0, wr_ready}, 32'd1);
      chk("seal_count", {26'b0, wr_count}, 32'd0);
      for (int i = 0; i < DEPTH; i++) rd(i, DW'(i - 8), 1'b1);
      tick();
      chk("rd_hold", {16'b0, rd_data}, 32'h0007);
      chk("basic_err", {31'b0, err}, 32'd0);
      // both banks full, writes dropped
      for (int i = 0; i < DEPTH; i++) wr(i, DW'(100 + 3 * i));
      seal();
      chk("both_full_wr_ready", {31'b0, wr_ready}, 32'd0);
      wr(3, 16'hdead);
      chk("drop_err", {31'b0, err}, 32'd1);
      chk("drop_count", {26'b0, wr_count}, 32'd0);
      rd(0, 16'hfff8, 1'b1);
      rd(5, 16'hfffd, 1'b1);
      rd(15, 16'h0007, 1'b1);
      release_bank();
      chk("rel_wr_ready", {31'b0, wr_ready}, 32'd1);
      chk("rel_rd_ready", {31'b0, rd_ready}, 32'd1);
      rd(2, 16'd106, 1'b1);
      // simultaneous release, seal, read and write
      do_reset();
      chk("rst2_err", {31'b0, err}, 32'd0);
      for (int i = 0; i < DEPTH; i++) wr(i, DW'(i - 8));
      seal();
      for (int i = 0; i < 4; i++) wr(i, DW'(16'h200 + i));
      rd_en = 1'b1;
      rd_addr = AW'(3);
      sb.push_back(16'hfffb);
      rd_exp_v = 1'b1;
      rd_release = 1'b1;
      wr_done = 1'b1;
      wr_valid = 1'b1;
      wr_addr = AW'(4);
      wr_data = 16'h0055;
      tick();
      {rd_en, rd_release, wr_done, wr_valid, rd_exp_v} = '0;
      chk("simul_wr_ready", {31'b0, wr_ready}, 32'd1);
      chk("simul_rd_ready", {31'b0, rd_ready}, 32'd1);
      chk("simul_count", {26'b0, wr_count}, 32'd0);
      chk("simul_err", {31'b0, err}, 32'd0);
      rd(4, 16'h0055, 1'b1);
      rd(1, 16'h0201, 1'b1);
      // out-of-range write and read with nothing sealed
      wr(7, 16'h0077);
      chk("pre_oor_count", {26'b0, wr_count}, 32'd1);
      wr(20, 16'hbeef);
      chk("oor_err", {31'b0, err}, 32'd1);
      chk("oor_count", {26'b0, wr_count}, 32'd1);
      release_bank();
      chk("empty_rd_ready", {31'b0, rd_ready}, 32'd0);
      rd(0, 16'h0000, 1'b0);
      chk("sticky_err", {31'b0, err}, 32'd1);
      // count saturates, last write wins
      for (int i = 0; i < DEPTH; i++) wr(i, DW'(16'h300 + i));
      chk("sat_count", {26'b0, wr_count}, 32'd16);
      seal();
      rd(7, 16'h0307, 1'b1);
      // reset mid-fill
      do_reset();
      for (int i = 0; i < 5; i++) wr(i, DW'(i));
      chk("mid_count", {26'b0, wr_count}, 32'd5);
      do_reset();
      chk("mid_rst_count", {26'b0, wr_count}, 32'd0);
      chk("mid_rst_rd_ready", {31'b0, rd_ready}, 32'd0);
      chk("mid_rst_wr_ready", {31'b0, wr_ready}, 32'd1);
      for (int i = 0; i < DEPTH; i++) wr(i, DW'(16'h1000 + i));
      seal();
      rd(0, 16'h1000, 1'b1);
      rd(15, 16'h100f, 1'b1);
      tick();
      chk("new_frame_err", {31'b0, err}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
